// File: rtl/obu_framer.sv
// -----------------------------------------------------------------------------
// obu_framer
//   Upstream stage of the OBU parser. Accepts the raw AV1 low-overhead
//   bitstream one byte per beat, decodes each OBU header and its LEB128
//   obu_size, and discards OBU types the parser does not handle. Payload bytes
//   of kept OBUs are packed MSB-first into 32-bit words. Each word carries
//   start/last/last_len/obu_type and is offered on a pop-driven interface.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   in_byte   bitstream byte; accepted when in_valid && in_ready
//   in_valid  in_byte valid
//   in_ready  framer can take a byte this cycle
//   data      packed payload word, first byte in [31:24]
//   avail     data/start/last/last_len/obu_type valid
//   start     word is the first of an OBU payload
//   last      word is the final word of an OBU payload
//   last_len  valid bytes in the final word (0 means 4), 0 when !last
//   obu_type  type of the OBU owning the current word
//   pop       consumer takes the current word (ignored when avail=0)
//   obu_done  one-cycle pulse after the final byte of any OBU is accepted
//   err       sticky protocol error, cleared only by rst
// -----------------------------------------------------------------------------
module obu_framer #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 2,
    parameter int MAX_LEB = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data,
    output logic              avail,
    output logic              start,
    output logic              last,
    output logic [LEN_W-1:0]  last_len,
    output logic [3:0]        obu_type,
    input  logic              pop,
    output logic              obu_done,
    output logic              err
);

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_EXT     = 3'd1,
        ST_SIZE    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DROP    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam logic [3:0] MAX_LEB_C = 4'(MAX_LEB);

    // OBU types forwarded to the parser: SEQ_HDR, FRAME_HDR, TILE_GROUP, FRAME.
    function automatic logic is_kept_type(input logic [3:0] t);
        logic r;
        case (t)
            4'd1, 4'd3, 4'd4, 4'd6: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

    // Drop byte b into lane idx of word w; lane 0 is the most significant byte.
    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                    input logic [1:0]        idx,
                                                    input logic [7:0]        b);
        logic [DATA_W-1:0] r;
        r = w;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            2'd3:    r[7:0]   = b;
            default: r = w;
        endcase
        return r;
    endfunction

    // Parser state
    state_t            state_q, state_d;
    logic [3:0]        type_q, type_d;
    logic [31:0]       size_q, size_d;
    logic [3:0]        leb_idx_q, leb_idx_d;
    logic [31:0]       remaining_q, remaining_d;
    logic              first_word_q, first_word_d;

    // Assembly register: holds a partial word, or a completed word that is
    // waiting for the output register to free up.
    logic [DATA_W-1:0] asm_data_q, asm_data_d;
    logic [1:0]        asm_idx_q, asm_idx_d;
    logic              asm_full_q, asm_full_d;
    logic              asm_start_q, asm_start_d;
    logic              asm_last_q, asm_last_d;
    logic [LEN_W-1:0]  asm_len_q, asm_len_d;
    logic [3:0]        asm_type_q, asm_type_d;

    // Output register
    logic [DATA_W-1:0] data_q, data_d;
    logic              avail_q, avail_d;
    logic              start_q, start_d;
    logic              last_q, last_d;
    logic [LEN_W-1:0]  last_len_q, last_len_d;
    logic [3:0]        obu_type_q, obu_type_d;
    logic              obu_done_q, obu_done_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;

    logic              accept_s;
    logic              out_free_s;
    logic [5:0]        leb_shamt_s;
    logic [31:0]       leb_part_s;
    logic [31:0]       size_acc_s;
    logic              leb_ovf_s;
    logic              pay_final_s;
    logic              word_done_s;
    logic [31:0]       remaining_dec_s;

    // Datapath helpers shared by the next-state logic.
    always_comb begin
        accept_s        = in_valid && in_ready_q;
        out_free_s      = !avail_q || pop;
        // 7*i computed as 8*i - i; bits shifted past bit 31 fall off the word.
        leb_shamt_s     = {leb_idx_q[2:0], 3'b000} - {3'b000, leb_idx_q[2:0]};
        leb_part_s      = {25'd0, in_byte[6:0]} << leb_shamt_s;
        size_acc_s      = size_q | leb_part_s;
        // The 5th LEB byte lands at bit 28; its bits [6:4] would exceed 32 bits.
        leb_ovf_s       = (leb_idx_q == 4'd4) && (in_byte[6:4] != 3'd0);
        pay_final_s     = (remaining_q == 32'd1);
        word_done_s     = (asm_idx_q == 2'd3) || pay_final_s;
        remaining_dec_s = (remaining_q != 32'd0) ? (remaining_q - 32'd1) : 32'd0;
    end

    // Next-state logic for the parser FSM, assembly and output registers.
    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        size_d       = size_q;
        leb_idx_d    = leb_idx_q;
        remaining_d  = remaining_q;
        first_word_d = first_word_q;
        asm_data_d   = asm_data_q;
        asm_idx_d    = asm_idx_q;
        asm_full_d   = asm_full_q;
        asm_start_d  = asm_start_q;
        asm_last_d   = asm_last_q;
        asm_len_d    = asm_len_q;
        asm_type_d   = asm_type_q;
        data_d       = data_q;
        avail_d      = avail_q;
        start_d      = start_q;
        last_d       = last_q;
        last_len_d   = last_len_q;
        obu_type_d   = obu_type_q;
        obu_done_d   = 1'b0;
        err_d        = err_q;
        in_ready_d   = in_ready_q;

        // Output stage: a completed word moves out as soon as the output
        // register is empty or being popped in this same cycle.
        if (state_q != ST_ERR) begin
            if (asm_full_q && out_free_s) begin
                data_d     = asm_data_q;
                avail_d    = 1'b1;
                start_d    = asm_start_q;
                last_d     = asm_last_q;
                last_len_d = asm_last_q ? asm_len_q : {LEN_W{1'b0}};
                obu_type_d = asm_type_q;
                asm_full_d = 1'b0;
            end else if (pop && avail_q) begin
                avail_d    = 1'b0;
                start_d    = 1'b0;
                last_d     = 1'b0;
                last_len_d = {LEN_W{1'b0}};
            end else begin
                avail_d    = avail_q;
            end
        end else begin
            avail_d = avail_q;
        end

        // Byte stage
        if (accept_s) begin
            case (state_q)
                ST_HDR: begin
                    if (in_byte[7] || !in_byte[1]) begin
                        state_d = ST_ERR;
                    end else begin
                        type_d    = in_byte[6:3];
                        size_d    = 32'd0;
                        leb_idx_d = 4'd0;
                        state_d   = in_byte[2] ? ST_EXT : ST_SIZE;
                    end
                end
                ST_EXT: begin
                    state_d = ST_SIZE;
                end
                ST_SIZE: begin
                    if (leb_idx_q >= MAX_LEB_C) begin
                        state_d = ST_ERR;
                    end else if (leb_ovf_s) begin
                        state_d = ST_ERR;
                    end else begin
                        size_d    = size_acc_s;
                        leb_idx_d = leb_idx_q + 4'd1;
                        if (!in_byte[7]) begin
                            if (size_acc_s == 32'd0) begin
                                obu_done_d = 1'b1;
                                state_d    = ST_HDR;
                            end else if (is_kept_type(type_q)) begin
                                remaining_d  = size_acc_s;
                                first_word_d = 1'b1;
                                asm_idx_d    = 2'd0;
                                state_d      = ST_PAYLOAD;
                            end else begin
                                remaining_d = size_acc_s;
                                state_d     = ST_DROP;
                            end
                        end else begin
                            state_d = ST_SIZE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // Lane 0 opens a fresh word so unused low lanes read as zero.
                    asm_data_d  = put_byte((asm_idx_q == 2'd0) ? {DATA_W{1'b0}} : asm_data_q,
                                           asm_idx_q, in_byte);
                    remaining_d = remaining_dec_s;
                    if (word_done_s) begin
                        asm_full_d   = 1'b1;
                        asm_start_d  = first_word_q;
                        asm_last_d   = pay_final_s;
                        asm_len_d    = pay_final_s ? size_q[LEN_W-1:0] : {LEN_W{1'b0}};
                        asm_type_d   = type_q;
                        first_word_d = 1'b0;
                        asm_idx_d    = 2'd0;
                    end else begin
                        asm_idx_d    = asm_idx_q + 2'd1;
                    end
                    if (pay_final_s) begin
                        obu_done_d = 1'b1;
                        state_d    = ST_HDR;
                    end else begin
                        state_d    = ST_PAYLOAD;
                    end
                end
                ST_DROP: begin
                    remaining_d = remaining_dec_s;
                    if (pay_final_s) begin
                        obu_done_d = 1'b1;
                        state_d    = ST_HDR;
                    end else begin
                        state_d    = ST_DROP;
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_ERR;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        err_d = err_q || (state_d == ST_ERR);

        // Registered ready: refuse payload bytes while both the assembly and
        // output registers hold completed words. Pop can only free space, so
        // a ready computed from the post-edge state is always safe.
        if (state_d == ST_ERR) begin
            in_ready_d = 1'b0;
        end else if ((state_d == ST_PAYLOAD) && asm_full_d && avail_d) begin
            in_ready_d = 1'b0;
        end else begin
            in_ready_d = 1'b1;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HDR;
            type_q       <= 4'd0;
            size_q       <= 32'd0;
            leb_idx_q    <= 4'd0;
            remaining_q  <= 32'd0;
            first_word_q <= 1'b0;
            asm_data_q   <= {DATA_W{1'b0}};
            asm_idx_q    <= 2'd0;
            asm_full_q   <= 1'b0;
            asm_start_q  <= 1'b0;
            asm_last_q   <= 1'b0;
            asm_len_q    <= {LEN_W{1'b0}};
            asm_type_q   <= 4'd0;
            data_q       <= {DATA_W{1'b0}};
            avail_q      <= 1'b0;
            start_q      <= 1'b0;
            last_q       <= 1'b0;
            last_len_q   <= {LEN_W{1'b0}};
            obu_type_q   <= 4'd0;
            obu_done_q   <= 1'b0;
            err_q        <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            size_q       <= size_d;
            leb_idx_q    <= leb_idx_d;
            remaining_q  <= remaining_d;
            first_word_q <= first_word_d;
            asm_data_q   <= asm_data_d;
            asm_idx_q    <= asm_idx_d;
            asm_full_q   <= asm_full_d;
            asm_start_q  <= asm_start_d;
            asm_last_q   <= asm_last_d;
            asm_len_q    <= asm_len_d;
            asm_type_q   <= asm_type_d;
            data_q       <= data_d;
            avail_q      <= avail_d;
            start_q      <= start_d;
            last_q       <= last_d;
            last_len_q   <= last_len_d;
            obu_type_q   <= obu_type_d;
            obu_done_q   <= obu_done_d;
            err_q        <= err_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign data     = data_q;
    assign avail    = avail_q;
    assign start    = start_q;
    assign last     = last_q;
    assign last_len = last_len_q;
    assign obu_type = obu_type_q;
    assign obu_done = obu_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_obu_framer.sv
// -----------------------------------------------------------------------------
// tb_obu_framer
//   Directed bench for obu_framer: a table of short OBU streams with their
//   expected output words, plus hand-written sequences for latency,
//   backpressure, error and mid-stream reset behaviour.
// -----------------------------------------------------------------------------
module tb_obu_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data;
    logic        avail;
    logic        start;
    logic        last;
    logic [1:0]  last_len;
    logic [3:0]  obu_type;
    logic        pop = 1'b0;
    logic        obu_done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    obu_framer #(.DATA_W(32), .LEN_W(2), .MAX_LEB(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data     (data),
        .avail    (avail),
        .start    (start),
        .last     (last),
        .last_len (last_len),
        .obu_type (obu_type),
        .pop      (pop),
        .obu_done (obu_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Bytes and words are right-aligned: element nbytes-1 is sent first.
    typedef struct packed {
        logic [4:0]        nbytes;
        logic [15:0][7:0]  bytes;
        logic [2:0]        nwords;
        logic [3:0][31:0]  words;
        logic [1:0]        last_len;
        logic [3:0]        typ;
        logic [3:0]        ndone;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic        start;
        logic        last;
        logic [1:0]  len;
        logic [3:0]  typ;
    } word_t;

    vec_t  vecs [6];
    word_t word_q [$];
    int    done_cnt = 0;

    // Consumer-side monitor: a word is taken at the next rising edge when avail && pop.
    always @(negedge clk) begin
        if (!rst && avail && pop) begin
            word_q.push_back({data, start, last, last_len, obu_type});
        end
        if (!rst && obu_done) begin
            done_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", {63'd0, in_ready}, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        pop      = 1'b0;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_avail"},    {63'd0, avail},    64'd0);
        check({tag, "_start"},    {63'd0, start},    64'd0);
        check({tag, "_last"},     {63'd0, last},     64'd0);
        check({tag, "_last_len"}, {62'd0, last_len}, 64'd0);
        check({tag, "_obu_type"}, {60'd0, obu_type}, 64'd0);
        check({tag, "_data"},     {32'd0, data},     64'd0);
        check({tag, "_obu_done"}, {63'd0, obu_done}, 64'd0);
        check({tag, "_err"},      {63'd0, err},      64'd0);
    endtask

    task automatic run_vec(input int vi);
        vec_t  v;
        word_t w;
        int    wb;
        int    db;
        int    nw;
        v   = vecs[vi];
        wb  = word_q.size();
        db  = done_cnt;
        nw  = int'(v.nwords);
        pop = 1'b1;
        for (int i = 0; i < int'(v.nbytes); i++) begin
            send_byte(v.bytes[int'(v.nbytes) - 1 - i]);
        end
        repeat (8) @(posedge clk);
        #1;
        check($sformatf("v%0d_nwords", vi), 64'(word_q.size() - wb), 64'(nw));
        for (int k = 0; k < nw; k++) begin
            if (wb + k < word_q.size()) begin
                w = word_q[wb + k];
                check($sformatf("v%0d_w%0d_data", vi, k), {32'd0, w.data}, {32'd0, v.words[nw - 1 - k]});
                check($sformatf("v%0d_w%0d_start", vi, k), {63'd0, w.start}, (k == 0) ? 64'd1 : 64'd0);
                check($sformatf("v%0d_w%0d_last", vi, k), {63'd0, w.last}, (k == nw - 1) ? 64'd1 : 64'd0);
                check($sformatf("v%0d_w%0d_len", vi, k), {62'd0, w.len},
                      (k == nw - 1) ? {62'd0, v.last_len} : 64'd0);
                check($sformatf("v%0d_w%0d_type", vi, k), {60'd0, w.typ}, {60'd0, v.typ});
            end
        end
        check($sformatf("v%0d_done", vi), 64'(done_cnt - db), {60'd0, v.ndone});
        check($sformatf("v%0d_err", vi), {63'd0, err}, 64'd0);
        check($sformatf("v%0d_ready", vi), {63'd0, in_ready}, 64'd1);
        check($sformatf("v%0d_idle", vi), {63'd0, avail}, 64'd0);
    endtask

    initial begin
        word_t w;
        int    wb;
        int    db;
        int    k;

        //           nbytes  bytes (first byte leftmost)        nwords words                       len   type  done
        vecs[0] = '{5'd7, 128'h0A05AABBCCDDEE,     3'd2, 128'hAABBCCDD_EE000000, 2'd1, 4'd1, 4'd1};
        vecs[1] = '{5'd2, 128'h1200,               3'd0, 128'h0,                 2'd0, 4'd0, 4'd1};
        vecs[2] = '{5'd6, 128'h1A0411223344,       3'd1, 128'h11223344,          2'd0, 4'd3, 4'd1};
        vecs[3] = '{5'd5, 128'h2A03010203,         3'd0, 128'h0,                 2'd0, 4'd0, 4'd1};
        vecs[4] = '{5'd7, 128'h260083009A8B7C,     3'd1, 128'h9A8B7C00,          2'd3, 4'd4, 4'd1};
        vecs[5] = '{5'd5, 128'h120032015E,         3'd1, 128'h5E000000,          2'd1, 4'd6, 4'd2};

        do_reset();
        check_reset_outputs("reset");

        for (int vi = 0; vi < 6; vi++) begin
            run_vec(vi);
        end

        // Latency: word appears one edge after its completing byte is accepted.
        pop = 1'b0;
        send_byte(8'h0A);
        send_byte(8'h01);
        send_byte(8'h77);
        check("lat_done_pulse", {63'd0, obu_done}, 64'd1);
        check("lat_avail_early", {63'd0, avail}, 64'd0);
        @(posedge clk);
        #1;
        check("lat_avail", {63'd0, avail}, 64'd1);
        check("lat_data", {32'd0, data}, 64'h77000000);
        check("lat_flags", {60'd0, start, last, last_len}, {60'd0, 1'b1, 1'b1, 2'd1});
        check("lat_done_clear", {63'd0, obu_done}, 64'd0);
        pop = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Type 6 with extension and two-byte LEB size 128.
        wb = word_q.size();
        db = done_cnt;
        send_byte(8'h36);
        send_byte(8'h00);
        send_byte(8'h80);
        send_byte(8'h01);
        for (int i = 0; i < 128; i++) begin
            send_byte(8'(i));
        end
        repeat (8) @(posedge clk);
        #1;
        check("big_nwords", 64'(word_q.size() - wb), 64'd32);
        check("big_done", 64'(done_cnt - db), 64'd1);
        for (int j = 0; j < 32; j++) begin
            if (wb + j < word_q.size()) begin
                w = word_q[wb + j];
                check($sformatf("big_w%0d_data", j), {32'd0, w.data},
                      {32'd0, 8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)});
                check($sformatf("big_w%0d_flags", j), {56'd0, w.start, w.last, w.len, w.typ},
                      {56'd0, (j == 0), (j == 31), 2'd0, 4'd6});
            end
        end

        // Backpressure: 12-byte type-1 payload with the consumer stalled.
        pop = 1'b0;
        wb  = word_q.size();
        db  = done_cnt;
        send_byte(8'h0A);
        send_byte(8'h0C);
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i));
        end
        check("bp_ready_drop", {63'd0, in_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_ready_held", {63'd0, in_ready}, 64'd0);
        check("bp_out_word0", {31'd0, avail, data}, {31'd0, 1'b1, 32'h01020304});
        pop = 1'b1;
        @(posedge clk);
        #1;
        pop = 1'b0;
        check("bp_ready_back", {63'd0, in_ready}, 64'd1);
        check("bp_out_word1", {32'd0, data}, 64'h05060708);
        for (int i = 9; i <= 12; i++) begin
            send_byte(8'(i));
        end
        pop = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("bp_nwords", 64'(word_q.size() - wb), 64'd3);
        check("bp_done", 64'(done_cnt - db), 64'd1);
        k = 0;
        while (k < 3 && wb + k < word_q.size()) begin
            w = word_q[wb + k];
            check($sformatf("bp_w%0d", k), {24'd0, w.data, w.start, w.last, w.len, w.typ},
                  {24'd0, 8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4), (k == 0), (k == 2), 2'd0, 4'd1});
            k++;
        end

        // Header without has_size.
        do_reset();
        send_byte(8'h08);
        repeat (3) @(posedge clk);
        #1;
        check("err_nosize", {62'd0, err, in_ready}, {62'd0, 1'b1, 1'b0});

        // Header with the forbidden bit set.
        do_reset();
        check("err_cleared", {63'd0, err}, 64'd0);
        send_byte(8'h8A);
        repeat (3) @(posedge clk);
        #1;
        check("err_forbidden", {62'd0, err, in_ready}, {62'd0, 1'b1, 1'b0});

        // LEB128 value wider than 32 bits.
        do_reset();
        send_byte(8'h0A);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        check("err_leb_pre", {63'd0, err}, 64'd0);
        send_byte(8'h7F);
        repeat (3) @(posedge clk);
        #1;
        check("err_leb", {62'd0, err, in_ready}, {62'd0, 1'b1, 1'b0});

        // Asynchronous reset in the middle of a payload, then a clean OBU.
        do_reset();
        pop = 1'b1;
        send_byte(8'h0A);
        send_byte(8'h05);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
